pipeline_hazard_ctrl: RTL and testbench

Central stall/flush controller for the five-stage pipeline. It drives the enable and flush/bubble inputs of the PC, IF/ID, ID/EX and EX/MEM registers. It covers three cases: load-use hazards between EX and ID, taken branches resolved in EX, and multi-cycle data-memory accesses through a req/ready handshake with a timeout. It also keeps a stall-cycle performance counter.

---
 rtl/pipe_ctrl_pkg.sv | 18 +
 rtl/hazard_detect.sv | 27 ++
 rtl/pipeline_hazard_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller and its helpers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: controller state encoding, default register-address width, zero-register index.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } ctrlState_e;

  localparam int DEFAULT_REG_W = 5;

  // Writes to register 0 are discarded, so a load targeting it never creates a hazard.
  localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard comparator between the instruction in EX and the one in ID.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the result is consumed by the stall controller or the forwarding unit.
// Ports: id_rs/id_rt/id_uses_rt describe the ID reads, ex_rd/ex_mem_read the EX load;
//        loadUse is high when ID needs a value the EX load has not fetched yet.
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = DEFAULT_REG_W
) (
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  output logic             loadUse
);

  logic rsHit;
  logic rtHit;

  assign rsHit   = (ex_rd == id_rs);
  // rt only matters when the ID instruction actually reads it (e.g. not for immediates).
  assign rtHit   = id_uses_rt & (ex_rd == id_rt);
  assign loadUse = ex_mem_read & (ex_rd != REG_W'(ZERO_REG)) & (rsHit | rtHit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the five-stage pipeline (load-use, taken branch, slow memory).
// Latency: outputs are combinational from registered state and current inputs; same-cycle effect.
// Backpressure: mem_req/mem_ready freezes every stage until ready; a long wait latches an error.
// Ports: clk/rst; ID/EX register fields and flags; branch_taken; mem_req/mem_ready handshake;
//        stage enables, ifid_flush, idex_bubble, sticky mem_timeout_err, saturating stall_cnt.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W       = DEFAULT_REG_W,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_bubble,
  output logic             exmem_en,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  ctrlState_e        state, nextState;
  logic [WAIT_W-1:0] waitCnt, waitCntNext;
  logic              branchPend, branchPendNext;
  logic              loadUse;
  logic              memStall;

  hazard_detect #(.REG_W(REG_W)) uHazard (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .loadUse     (loadUse)
  );

  assign memStall = mem_req & ~mem_ready;

  always_comb begin
    nextState      = state;
    waitCntNext    = waitCnt;
    branchPendNext = branchPend;
    pc_en          = 1'b1;
    ifid_en        = 1'b1;
    idex_en        = 1'b1;
    exmem_en       = 1'b1;
    ifid_flush     = 1'b0;
    idex_bubble    = 1'b0;

    unique case (state)
      RUN: begin
        if (memStall) begin
          pc_en          = 1'b0;
          ifid_en        = 1'b0;
          idex_en        = 1'b0;
          exmem_en       = 1'b0;
          // A branch resolved while frozen must still squash once the pipe moves.
          branchPendNext = branch_taken;
          nextState      = MEM_WAIT;
          waitCntNext    = WAIT_W'(1);
        end else if (branch_taken) begin
          // Squashing the wrong-path instructions also removes any load-use consumer.
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (loadUse) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_bubble = 1'b1;
        end
      end

      MEM_WAIT: begin
        if (!mem_ready) begin
          pc_en    = 1'b0;
          ifid_en  = 1'b0;
          idex_en  = 1'b0;
          exmem_en = 1'b0;
          if (branch_taken) begin
            branchPendNext = 1'b1;
          end
          // waitCnt already includes the entry cycle, so this is the last allowed miss.
          if (waitCnt >= WAIT_W'(MEM_TIMEOUT - 1)) begin
            nextState = ERROR;
          end else begin
            waitCntNext = waitCnt + WAIT_W'(1);
          end
        end else begin
          if (branchPend || branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (loadUse) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
          end
          branchPendNext = 1'b0;
          waitCntNext    = '0;
          nextState      = RUN;
        end
      end

      ERROR: begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
      end

      default: begin
        nextState = RUN;
      end
    endcase

    // Hold the whole pipe with NOPs injected while reset is asserted.
    if (rst) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end
  end

  assign mem_timeout_err = (state == ERROR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      waitCnt    <= '0;
      branchPend <= 1'b0;
    end else begin
      state      <= nextState;
      waitCnt    <= waitCntNext;
      branchPend <= branchPendNext;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (!pc_en && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: table vectors, corner sequences, random vs model.
// Latency: inputs change on negedge, outputs sampled 1 time unit later; stall_cnt read before the next posedge.
// Backpressure: n/a.
module tb_pipeline_hazard_ctrl;

  localparam int REG_W       = 5;
  localparam int MEM_TIMEOUT = 15;
  localparam int CNT_W       = 6;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  // Output vector order: {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en}
  localparam logic [5:0] O_RST    = 6'b001010;
  localparam logic [5:0] O_IDLE   = 6'b110101;
  localparam logic [5:0] O_FREEZE = 6'b000000;
  localparam logic [5:0] O_SQUASH = 6'b111111;
  localparam logic [5:0] O_LU     = 6'b000111;

  logic             clk = 1'b0;
  logic             rst;
  logic [REG_W-1:0] id_rs, id_rt, ex_rd;
  logic             id_uses_rt, ex_mem_read, branch_taken, mem_req, mem_ready;
  logic             pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en;
  logic             mem_timeout_err;
  logic [CNT_W-1:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_W(REG_W), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .ex_rd           (ex_rd),
    .ex_mem_read     (ex_mem_read),
    .branch_taken    (branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .pc_en           (pc_en),
    .ifid_en         (ifid_en),
    .ifid_flush      (ifid_flush),
    .idex_en         (idex_en),
    .idex_bubble     (idex_bubble),
    .exmem_en        (exmem_en),
    .mem_timeout_err (mem_timeout_err),
    .stall_cnt       (stall_cnt)
  );

  typedef struct {
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic             ur;
    logic [REG_W-1:0] rd;
    logic             mr;
    logic             bt;
    logic             req;
    logic             rdy;
    logic [5:0]       exp;
  } vec_t;

  vec_t tbl[11];

  function automatic logic [5:0] outs();
    return {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                       input logic ur, input logic [REG_W-1:0] rd, input logic mr,
                       input logic bt, input logic req, input logic rdy);
    @(negedge clk);
    rst          = r;
    id_rs        = rs;
    id_rt        = rt;
    id_uses_rt   = ur;
    ex_rd        = rd;
    ex_mem_read  = mr;
    branch_taken = bt;
    mem_req      = req;
    mem_ready    = rdy;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic memCycle(input logic bt, input logic rdy);
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0, bt, 1'b1, rdy);
  endtask

  task automatic doReset();
    drive(1'b1, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Reference model state: length of the current not-ready run (0 = no access outstanding).
  int   streak;
  bit   errored;
  bit   brSeen;
  int   mStall;

  initial begin
    logic [5:0] e;
    logic       eErr;
    logic       lu;
    int         expStall;
    int         drought;
    logic       r, ur, mr, bt, req, rdy;
    logic [REG_W-1:0] rs, rt, rd;

    tbl[0]  = '{rs: 5'd0, rt: 5'd0, ur: 1'b0, rd: 5'd0, mr: 1'b0, bt: 1'b0, req: 1'b0, rdy: 1'b0, exp: O_IDLE};
    tbl[1]  = '{rs: 5'd5, rt: 5'd0, ur: 1'b0, rd: 5'd5, mr: 1'b1, bt: 1'b0, req: 1'b0, rdy: 1'b0, exp: O_LU};
    tbl[2]  = '{rs: 5'd0, rt: 5'd0, ur: 1'b1, rd: 5'd0, mr: 1'b1, bt: 1'b0, req: 1'b0, rdy: 1'b0, exp: O_IDLE};
    tbl[3]  = '{rs: 5'd3, rt: 5'd5, ur: 1'b0, rd: 5'd5, mr: 1'b1, bt: 1'b0, req: 1'b0, rdy: 1'b0, exp: O_IDLE};
    tbl[4]  = '{rs: 5'd3, rt: 5'd5, ur: 1'b1, rd: 5'd5, mr: 1'b1, bt: 1'b0, req: 1'b0, rdy: 1'b0, exp: O_LU};
    tbl[5]  = '{rs: 5'd5, rt: 5'd5, ur: 1'b1, rd: 5'd5, mr: 1'b0, bt: 1'b0, req: 1'b0, rdy: 1'b0, exp: O_IDLE};
    tbl[6]  = '{rs: 5'd9, rt: 5'd0, ur: 1'b0, rd: 5'd9, mr: 1'b1, bt: 1'b1, req: 1'b0, rdy: 1'b0, exp: O_SQUASH};
    tbl[7]  = '{rs: 5'd1, rt: 5'd2, ur: 1'b1, rd: 5'd3, mr: 1'b0, bt: 1'b1, req: 1'b0, rdy: 1'b0, exp: O_SQUASH};
    tbl[8]  = '{rs: 5'd1, rt: 5'd2, ur: 1'b1, rd: 5'd3, mr: 1'b1, bt: 1'b0, req: 1'b1, rdy: 1'b1, exp: O_IDLE};
    tbl[9]  = '{rs: 5'd0, rt: 5'd0, ur: 1'b0, rd: 5'd0, mr: 1'b0, bt: 1'b0, req: 1'b0, rdy: 1'b1, exp: O_IDLE};
    tbl[10] = '{rs: 5'd31, rt: 5'd7, ur: 1'b1, rd: 5'd31, mr: 1'b1, bt: 1'b0, req: 1'b1, rdy: 1'b1, exp: O_LU};

    // Reset behaviour
    doReset();
    doReset();
    chk("reset_outs", 32'(outs()), 32'(O_RST));
    chk("reset_err", 32'(mem_timeout_err), 32'd0);
    chk("reset_cnt", 32'(stall_cnt), 32'd0);
    idle();
    chk("post_reset_outs", 32'(outs()), 32'(O_IDLE));

    // Single-cycle RUN vectors
    expStall = 0;
    for (int i = 0; i < 11; i++) begin
      drive(1'b0, tbl[i].rs, tbl[i].rt, tbl[i].ur, tbl[i].rd, tbl[i].mr, tbl[i].bt, tbl[i].req, tbl[i].rdy);
      chk($sformatf("vec%0d_outs", i), 32'(outs()), 32'(tbl[i].exp));
      if (!tbl[i].exp[5]) expStall++;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_cnt", i), 32'(stall_cnt), 32'(expStall));
    end

    // Memory wait with a branch resolved mid-wait
    doReset();
    memCycle(1'b0, 1'b0);
    chk("mw_c1", 32'(outs()), 32'(O_FREEZE));
    memCycle(1'b1, 1'b0);
    chk("mw_c2", 32'(outs()), 32'(O_FREEZE));
    memCycle(1'b0, 1'b0);
    chk("mw_c3", 32'(outs()), 32'(O_FREEZE));
    memCycle(1'b0, 1'b1);
    chk("mw_release", 32'(outs()), 32'(O_SQUASH));
    idle();
    chk("mw_after", 32'(outs()), 32'(O_IDLE));
    chk("mw_cnt", 32'(stall_cnt), 32'd3);

    // Release cycle without a branch falls back to the load-use rule
    memCycle(1'b0, 1'b0);
    chk("mwlu_wait", 32'(outs()), 32'(O_FREEZE));
    drive(1'b0, 5'd7, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("mwlu_release", 32'(outs()), 32'(O_LU));
    idle();
    chk("mwlu_cnt", 32'(stall_cnt), 32'd5);

    // Reset mid-wait discards the pending branch
    memCycle(1'b1, 1'b0);
    doReset();
    chk("rmw_outs", 32'(outs()), 32'(O_RST));
    chk("rmw_cnt", 32'(stall_cnt), 32'd0);
    memCycle(1'b0, 1'b0);
    memCycle(1'b0, 1'b1);
    chk("rmw_release", 32'(outs()), 32'(O_IDLE));

    // Timeout into the sticky error state, counter saturation, reset exit
    doReset();
    for (int i = 1; i <= MEM_TIMEOUT; i++) begin
      memCycle(1'b0, 1'b0);
      chk($sformatf("to_c%0d_err", i), 32'(mem_timeout_err), 32'd0);
      chk($sformatf("to_c%0d_outs", i), 32'(outs()), 32'(O_FREEZE));
    end
    memCycle(1'b0, 1'b0);
    chk("to_err_set", 32'(mem_timeout_err), 32'd1);
    chk("to_err_outs", 32'(outs()), 32'(O_FREEZE));
    chk("to_err_cnt", 32'(stall_cnt), 32'(MEM_TIMEOUT));
    for (int i = 0; i < 60; i++) memCycle(1'b1, 1'b1);
    chk("to_sticky_err", 32'(mem_timeout_err), 32'd1);
    chk("to_sticky_outs", 32'(outs()), 32'(O_FREEZE));
    chk("to_sat_cnt", 32'(stall_cnt), 32'(CNT_MAX));
    doReset();
    chk("to_rst_err", 32'(mem_timeout_err), 32'd0);
    chk("to_rst_cnt", 32'(stall_cnt), 32'd0);
    chk("to_rst_outs", 32'(outs()), 32'(O_RST));

    // Randomized stimulus against the reference model
    doReset();
    streak  = 0;
    errored = 0;
    brSeen  = 0;
    mStall  = 0;
    drought = 0;
    for (int c = 0; c < 1500; c++) begin
      r   = ($urandom_range(0, 149) == 0);
      rs  = REG_W'($urandom_range(0, 3));
      rt  = REG_W'($urandom_range(0, 3));
      rd  = REG_W'($urandom_range(0, 3));
      ur  = 1'($urandom_range(0, 1));
      mr  = 1'($urandom_range(0, 1));
      bt  = ($urandom_range(0, 3) == 0);
      req = 1'($urandom_range(0, 1));
      if (drought == 0 && $urandom_range(0, 59) == 0) drought = $urandom_range(8, 20);
      if (drought > 0) begin
        rdy = 1'b0;
        drought--;
      end else begin
        rdy = ($urandom_range(0, 3) != 0);
      end
      drive(r, rs, rt, ur, rd, mr, bt, req, rdy);

      if (r) begin
        streak  = 0;
        errored = 0;
        brSeen  = 0;
        mStall  = 0;
        e       = O_RST;
        eErr    = 1'b0;
      end else begin
        lu   = mr && (rd != 0) && ((rd == rs) || (ur && (rd == rt)));
        e    = O_IDLE;
        eErr = errored;
        if (errored) begin
          e = O_FREEZE;
        end else if (streak > 0) begin
          if (!rdy) begin
            e      = O_FREEZE;
            brSeen = brSeen | bt;
            streak++;
            if (streak >= MEM_TIMEOUT) errored = 1'b1;
          end else begin
            if (brSeen || bt) e = O_SQUASH;
            else if (lu)      e = O_LU;
            streak = 0;
            brSeen = 0;
          end
        end else begin
          if (req && !rdy) begin
            e      = O_FREEZE;
            streak = 1;
            brSeen = bt;
          end else if (bt) begin
            e = O_SQUASH;
          end else if (lu) begin
            e = O_LU;
          end
        end
      end

      chk($sformatf("rnd%0d_cnt", c), 32'(stall_cnt), 32'(mStall));
      chk($sformatf("rnd%0d_outs", c), 32'(outs()), 32'(e));
      chk($sformatf("rnd%0d_err", c), 32'(mem_timeout_err), 32'(eErr));
      if (!r && !e[5] && mStall < CNT_MAX) mStall++;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
